// File: rtl/icache_pf_ctrl.sv
// Instruction-cache control FSM for a read-only N-way set-associative cache.
// Blocking demand fills, plus a sequential prefetcher that probes lines
// +1..+PF_DIST after each demand hit, and saturating performance counters.
module icache_pf_ctrl #(
  parameter int WAYS    = 4,
  parameter int PF_DIST = 2,
  parameter int CNT_W   = 32,
  localparam int WB     = $clog2(WAYS),
  localparam int OW     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  output logic             mem_resp,
  input  logic [WAYS-1:0]  hit_i,
  input  logic [WAYS-1:0]  valid_i,
  input  logic [WAYS-2:0]  lru_i,
  input  logic [WAYS-1:0]  nhit_i,
  input  logic [WAYS-1:0]  nvalid_i,
  input  logic [WAYS-2:0]  nlru_i,
  input  logic             pf_set_conflict_i,
  input  logic             pf_enable_i,
  output logic [OW-1:0]    pf_offset_o,
  output logic             load_pf_line_o,
  output logic [WB-1:0]    dout_way_o,
  output logic             lru_update_o,
  output logic [WB-1:0]    lru_way_o,
  output logic [WB-1:0]    fill_way_o,
  output logic             fill_load_o,
  output logic [WB-1:0]    pf_way_o,
  output logic             pf_load_o,
  output logic             paddr_sel_o,
  output logic             pmem_read,
  input  logic             pmem_resp,
  output logic [CNT_W-1:0] hit_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o,
  output logic [CNT_W-1:0] pf_cnt_o
);

  typedef enum logic [1:0] {
    HIT_CHECK,
    FILL,
    PF_PROBE,
    PF_FILL
  } state_t;

  localparam logic [OW-1:0] PF_LAST = OW'(PF_DIST);

  state_t        state_q, state_d;
  logic [OW-1:0] pf_k_q, pf_k_d;
  logic [WB-1:0] pf_way_q, pf_way_d;
  logic          hit_inc, miss_inc, pf_inc;

  // Replacement choice: lowest invalid way first, otherwise follow the
  // tree-PLRU bits from the root (bit 1 -> lower half, bit 0 -> upper half).
  function automatic logic [WB-1:0] victim(input logic [WAYS-1:0] vld,
                                           input logic [WAYS-2:0] lru);
    logic [WB-1:0]   way;
    logic [WAYS-2:0] sh;
    logic            found;
    int              node;
    way   = '0;
    found = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (!vld[i] && !found) begin
        way   = i[WB-1:0];
        found = 1'b1;
      end
    end
    if (!found) begin
      node = 0;
      for (int l = 0; l < WB; l++) begin
        sh = lru >> node;
        if (sh[0]) node = 2 * node + 1;
        else       node = 2 * node + 2;
      end
      way = WB'(node - (WAYS - 1));
    end
    return way;
  endfunction

  logic [WB-1:0] hit_way;
  logic          hit_any, blocked, demand_hit, demand_miss, demand_wait;

  // Decode the one-hot demand hit and classify the current request.
  always_comb begin
    hit_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (hit_i[i]) hit_way = hit_way | i[WB-1:0];
    end
    hit_any     = |hit_i;
    // The way being prefetched into is unreadable until its burst lands.
    blocked     = (state_q == PF_FILL) && pf_set_conflict_i && hit_i[pf_way_q];
    demand_hit  = mem_read && hit_any && !blocked && (state_q != FILL);
    demand_miss = mem_read && !hit_any;
    demand_wait = mem_read && (!hit_any || blocked);
  end

  // Next-state and output decode.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // so no path can leave a value unassigned and infer a latch.
    state_d        = state_q;
    pf_k_d         = pf_k_q;
    pf_way_d       = pf_way_q;
    mem_resp       = 1'b0;
    dout_way_o     = '0;
    lru_update_o   = 1'b0;
    lru_way_o      = '0;
    fill_way_o     = '0;
    fill_load_o    = 1'b0;
    pf_way_o       = '0;
    pf_load_o      = 1'b0;
    paddr_sel_o    = 1'b0;
    pmem_read      = 1'b0;
    pf_offset_o    = '0;
    load_pf_line_o = 1'b0;
    hit_inc        = 1'b0;
    miss_inc       = 1'b0;
    pf_inc         = 1'b0;

    if (demand_hit) begin
      mem_resp     = 1'b1;
      dout_way_o   = hit_way;
      lru_update_o = 1'b1;
      lru_way_o    = hit_way;
      hit_inc      = 1'b1;
    end

    case (state_q)
      HIT_CHECK: begin
        if (demand_miss) begin
          miss_inc = 1'b1;
          state_d  = FILL;
        end else if (demand_hit && pf_enable_i) begin
          pf_k_d  = OW'(1);
          state_d = PF_PROBE;
        end
      end
      FILL: begin
        pmem_read  = 1'b1;
        fill_way_o = victim(valid_i, lru_i);
        if (pmem_resp) begin
          fill_load_o = 1'b1;
          state_d     = HIT_CHECK;
        end
      end
      PF_PROBE: begin
        pf_offset_o = pf_k_q;
        // A demand miss outranks any prefetch not yet on the bus.
        if (demand_miss) begin
          miss_inc = 1'b1;
          state_d  = FILL;
        end else if (|nhit_i) begin
          if (pf_k_q < PF_LAST) pf_k_d = pf_k_q + OW'(1);
          else                  state_d = HIT_CHECK;
        end else begin
          load_pf_line_o = 1'b1;
          pf_way_d       = victim(nvalid_i, nlru_i);
          pf_inc         = 1'b1;
          state_d        = PF_FILL;
        end
      end
      PF_FILL: begin
        pmem_read   = 1'b1;
        paddr_sel_o = 1'b1;
        pf_way_o    = pf_way_q;
        if (pmem_resp) begin
          pf_load_o = 1'b1;
          // A stalled demand drops the rest of the chain and is re-checked.
          if (demand_wait || pf_k_q >= PF_LAST) begin
            state_d = HIT_CHECK;
          end else begin
            pf_k_d  = pf_k_q + OW'(1);
            state_d = PF_PROBE;
          end
        end
      end
      default: state_d = HIT_CHECK;
    endcase
  end

  // FSM state, prefetch cursor and prefetch victim registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q  <= HIT_CHECK;
      pf_k_q   <= '0;
      pf_way_q <= '0;
    end else begin
      state_q  <= state_d;
      pf_k_q   <= pf_k_d;
      pf_way_q <= pf_way_d;
    end
  end

  // Saturating performance counters, one step per resolved event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      pf_cnt_o   <= '0;
    end else begin
      if (hit_inc  && hit_cnt_o  != '1) hit_cnt_o  <= hit_cnt_o  + CNT_W'(1);
      if (miss_inc && miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + CNT_W'(1);
      if (pf_inc   && pf_cnt_o   != '1) pf_cnt_o   <= pf_cnt_o   + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_icache_pf_ctrl.sv
// Self-checking bench for icache_pf_ctrl (WAYS=4, PF_DIST=2, narrow counters
// so saturation is reachable). Expected values come from a request-level
// model: hit latency 0, miss latency = memory latency + 1, spec victim table.
module tb_icache_pf_ctrl;
  localparam int WAYS    = 4;
  localparam int PF_DIST = 2;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mem_read, mem_resp;
  logic [3:0]       hit_i, valid_i, nhit_i, nvalid_i;
  logic [2:0]       lru_i, nlru_i;
  logic             pf_set_conflict_i, pf_enable_i;
  logic [2:0]       pf_offset_o;
  logic             load_pf_line_o;
  logic [1:0]       dout_way_o, lru_way_o, fill_way_o, pf_way_o;
  logic             lru_update_o, fill_load_o, pf_load_o, paddr_sel_o;
  logic             pmem_read, pmem_resp;
  logic [CNT_W-1:0] hit_cnt_o, miss_cnt_o, pf_cnt_o;

  int checks   = 0;
  int failures = 0;
  int exp_hit  = 0;
  int exp_miss = 0;
  int exp_pf   = 0;

  icache_pf_ctrl #(.WAYS(WAYS), .PF_DIST(PF_DIST), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_resp(mem_resp),
    .hit_i(hit_i), .valid_i(valid_i), .lru_i(lru_i),
    .nhit_i(nhit_i), .nvalid_i(nvalid_i), .nlru_i(nlru_i),
    .pf_set_conflict_i(pf_set_conflict_i), .pf_enable_i(pf_enable_i),
    .pf_offset_o(pf_offset_o), .load_pf_line_o(load_pf_line_o),
    .dout_way_o(dout_way_o), .lru_update_o(lru_update_o), .lru_way_o(lru_way_o),
    .fill_way_o(fill_way_o), .fill_load_o(fill_load_o),
    .pf_way_o(pf_way_o), .pf_load_o(pf_load_o), .paddr_sel_o(paddr_sel_o),
    .pmem_read(pmem_read), .pmem_resp(pmem_resp),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o), .pf_cnt_o(pf_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] sat(input int v);
    if (v >= (1 << CNT_W) - 1) return '1;
    return CNT_W'(v);
  endfunction

  // Victim choice straight from the WAYS=4 table.
  function automatic logic [1:0] ref_victim(input logic [3:0] v, input logic [2:0] lru);
    if (!v[0]) return 2'd0;
    if (!v[1]) return 2'd1;
    if (!v[2]) return 2'd2;
    if (!v[3]) return 2'd3;
    case (lru)
      3'b011, 3'b111: return 2'd0;
      3'b001, 3'b101: return 2'd1;
      3'b100, 3'b110: return 2'd2;
      default:        return 2'd3;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read = 0; hit_i = 0; valid_i = 0; lru_i = 0;
    nhit_i = 0; nvalid_i = 0; nlru_i = 0;
    pf_set_conflict_i = 0; pf_enable_i = 0; pmem_resp = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #3;
    pmem_resp = 1;
    #1;
    checks++;
    if ({mem_resp, pmem_read, fill_load_o, pf_load_o, load_pf_line_o, lru_update_o, paddr_sel_o} !== 7'd0) begin
      failures++; $display("FAIL reset_strobes: got %b expected 0",
        {mem_resp, pmem_read, fill_load_o, pf_load_o, load_pf_line_o, lru_update_o, paddr_sel_o});
    end
    checks++;
    if ({pf_offset_o, dout_way_o, lru_way_o, fill_way_o, pf_way_o} !== 11'd0) begin
      failures++; $display("FAIL reset_ways: got %h expected 0",
        {pf_offset_o, dout_way_o, lru_way_o, fill_way_o, pf_way_o});
    end
    checks++;
    if ({hit_cnt_o, miss_cnt_o, pf_cnt_o} !== '0) begin
      failures++; $display("FAIL reset_counters: got %h expected 0", {hit_cnt_o, miss_cnt_o, pf_cnt_o});
    end
    pmem_resp = 0;
    #2 rst_n = 1;
    tick();
  endtask

  // One demand request with prefetch off; hit_way < 0 means a miss.
  task automatic demand(input string name, input logic [3:0] vld, input logic [2:0] lru,
                        input int hit_way, input int lat);
    int         exp_lat, cyc, pcnt;
    logic [1:0] exp_way;
    bit         present, was_miss, done;
    present  = (hit_way >= 0);
    was_miss = !present;
    exp_way  = present ? 2'(hit_way) : ref_victim(vld, lru);
    exp_lat  = present ? 0 : lat + 1;
    cyc = 0; pcnt = 0; done = 0;
    pf_enable_i = 0; pf_set_conflict_i = 0;
    valid_i = vld; lru_i = lru; mem_read = 1;
    while (!done && cyc < 40) begin
      hit_i     = present ? (4'b0001 << exp_way) : 4'b0000;
      pmem_resp = 0;
      #1;
      if (pmem_read) begin
        pcnt++;
        pmem_resp = (pcnt == lat);
      end
      #1;
      checks++;
      if ({load_pf_line_o, pf_load_o, pmem_read & paddr_sel_o, pf_offset_o} !== 6'd0) begin
        failures++; $display("FAIL %s no_prefetch cyc=%0d: got %b expected 0", name, cyc,
          {load_pf_line_o, pf_load_o, pmem_read & paddr_sel_o, pf_offset_o});
      end
      if (fill_load_o) begin
        checks++;
        if (fill_way_o !== exp_way) begin
          failures++; $display("FAIL %s fill_way: got %0d expected %0d", name, fill_way_o, exp_way);
        end
        present = 1;
        valid_i[exp_way] = 1'b1;
      end
      if (mem_resp) begin
        done = 1;
        checks++;
        if (cyc != exp_lat) begin
          failures++; $display("FAIL %s latency: got %0d expected %0d", name, cyc, exp_lat);
        end
        checks++;
        if ({dout_way_o, lru_way_o, lru_update_o} !== {exp_way, exp_way, 1'b1}) begin
          failures++; $display("FAIL %s resp_way: got dout=%0d lru=%0d upd=%b expected %0d", name,
            dout_way_o, lru_way_o, lru_update_o, exp_way);
        end
      end
      tick();
      if (!done) cyc++;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s timeout: got no mem_resp expected one within 40 cycles", name);
    end
    if (was_miss) begin
      checks++;
      if (pcnt != lat) begin
        failures++; $display("FAIL %s pmem_read_cycles: got %0d expected %0d", name, pcnt, lat);
      end
      exp_miss++;
    end
    if (done) exp_hit++;
    mem_read = 0; hit_i = 0; pmem_resp = 0;
    #1;
    checks++;
    if ({hit_cnt_o, miss_cnt_o, pf_cnt_o} !== {sat(exp_hit), sat(exp_miss), sat(exp_pf)}) begin
      failures++; $display("FAIL %s counters: got h=%0d m=%0d p=%0d expected h=%0d m=%0d p=%0d", name,
        hit_cnt_o, miss_cnt_o, pf_cnt_o, sat(exp_hit), sat(exp_miss), sat(exp_pf));
    end
    tick();
  endtask

  task automatic test_cold_miss();
    demand("cold_miss", 4'b0000, 3'b000, -1, 5);
  endtask

  task automatic test_victim_select();
    demand("victim_lru100", 4'b1111, 3'b100, -1, 3);
    demand("victim_lru010", 4'b1111, 3'b010, -1, 2);
    demand("victim_invalid2", 4'b1011, 3'b011, -1, 1);
  endtask

  // Demand hit followed by a prefetch walk over k=1..PF_DIST.
  task automatic test_prefetch_chain(input int trials);
    bit         present [PF_DIST+1];
    logic [3:0] nv [PF_DIST+1];
    logic [2:0] nl [PF_DIST+1];
    logic [1:0] dway, vic;
    int         lat;
    for (int t = 0; t < trials; t++) begin
      for (int k = 1; k <= PF_DIST; k++) begin
        present[k] = 1'($urandom_range(0, 1));
        nv[k]      = 4'($urandom);
        nl[k]      = 3'($urandom);
      end
      lat = $urandom_range(1, 5);
      if (t == 0) begin
        present[1] = 1; present[2] = 0; nv[2] = 4'hF; nl[2] = 3'b100; lat = 3;
      end
      dway = 2'($urandom_range(0, 3));
      pf_enable_i = 1; mem_read = 1; hit_i = 4'b0001 << dway; valid_i = 4'hF;
      #1;
      checks++;
      if ({mem_resp, dout_way_o} !== {1'b1, dway}) begin
        failures++; $display("FAIL chain%0d demand_hit: got resp=%b way=%0d expected 1/%0d", t,
          mem_resp, dout_way_o, dway);
      end
      tick();
      exp_hit++;
      mem_read = 0; hit_i = 0;
      for (int k = 1; k <= PF_DIST; k++) begin
        nhit_i = present[k] ? 4'b0001 : 4'b0000;
        nvalid_i = nv[k]; nlru_i = nl[k];
        #1;
        checks++;
        if ({pf_offset_o, load_pf_line_o, pmem_read} !== {3'(k), ~present[k], 1'b0}) begin
          failures++; $display("FAIL chain%0d probe k=%0d: got off=%0d ld=%b rd=%b expected off=%0d ld=%b rd=0",
            t, k, pf_offset_o, load_pf_line_o, pmem_read, k, ~present[k]);
        end
        tick();
        if (!present[k]) begin
          exp_pf++;
          vic = ref_victim(nv[k], nl[k]);
          for (int c = 1; c <= lat; c++) begin
            pmem_resp = (c == lat);
            #1;
            checks++;
            if ({pmem_read, paddr_sel_o, pf_way_o, pf_load_o, mem_resp} !== {1'b1, 1'b1, vic, (c == lat), 1'b0}) begin
              failures++; $display("FAIL chain%0d pf_fill c=%0d: got %b expected %b", t, c,
                {pmem_read, paddr_sel_o, pf_way_o, pf_load_o, mem_resp}, {1'b1, 1'b1, vic, (c == lat), 1'b0});
            end
            tick();
          end
          pmem_resp = 0;
        end
      end
      nhit_i = 0;
      #1;
      checks++;
      if ({pmem_read, load_pf_line_o, pf_offset_o} !== 5'd0) begin
        failures++; $display("FAIL chain%0d back_to_idle: got %b expected 0", t,
          {pmem_read, load_pf_line_o, pf_offset_o});
      end
      checks++;
      if ({hit_cnt_o, pf_cnt_o} !== {sat(exp_hit), sat(exp_pf)}) begin
        failures++; $display("FAIL chain%0d counters: got h=%0d p=%0d expected h=%0d p=%0d", t,
          hit_cnt_o, pf_cnt_o, sat(exp_hit), sat(exp_pf));
      end
      tick();
    end
    pf_enable_i = 0;
  endtask

  // Hits during a prefetch burst: other set served at once, victim way stalls.
  task automatic test_pf_fill_hits();
    pf_enable_i = 1; mem_read = 1; hit_i = 4'b0001; valid_i = 4'hF;
    #1; tick(); exp_hit++;
    mem_read = 0; hit_i = 0; pf_enable_i = 0;
    nhit_i = 0; nvalid_i = 4'b1011; nlru_i = 3'b000;
    #1;
    checks++;
    if (load_pf_line_o !== 1'b1) begin
      failures++; $display("FAIL pfhit load_pf_line: got %b expected 1", load_pf_line_o);
    end
    tick(); exp_pf++;
    mem_read = 1; hit_i = 4'b0100; pf_set_conflict_i = 0;
    #1;
    checks++;
    if ({mem_resp, dout_way_o, pmem_read, paddr_sel_o, pf_way_o} !== {1'b1, 2'd2, 1'b1, 1'b1, 2'd2}) begin
      failures++; $display("FAIL pfhit other_set: got %b expected %b",
        {mem_resp, dout_way_o, pmem_read, paddr_sel_o, pf_way_o}, {1'b1, 2'd2, 1'b1, 1'b1, 2'd2});
    end
    tick(); exp_hit++;
    pf_set_conflict_i = 1;
    for (int c = 2; c <= 6; c++) begin
      pmem_resp = (c == 6);
      #1;
      checks++;
      if ({mem_resp, pf_load_o} !== {1'b0, (c == 6)}) begin
        failures++; $display("FAIL pfhit blocked c=%0d: got resp=%b load=%b expected 0/%b", c,
          mem_resp, pf_load_o, (c == 6));
      end
      if (c == 4) begin
        checks++;
        if (hit_cnt_o !== sat(exp_hit)) begin
          failures++; $display("FAIL pfhit stall_count: got %0d expected %0d", hit_cnt_o, sat(exp_hit));
        end
      end
      tick();
    end
    pmem_resp = 0;
    #1;
    checks++;
    if ({mem_resp, dout_way_o, pmem_read, pf_offset_o} !== {1'b1, 2'd2, 1'b0, 3'd0}) begin
      failures++; $display("FAIL pfhit served_after: got %b expected %b",
        {mem_resp, dout_way_o, pmem_read, pf_offset_o}, {1'b1, 2'd2, 1'b0, 3'd0});
    end
    tick(); exp_hit++;
    mem_read = 0; hit_i = 0; pf_set_conflict_i = 0;
    #1;
    checks++;
    if ({hit_cnt_o, pf_cnt_o} !== {sat(exp_hit), sat(exp_pf)}) begin
      failures++; $display("FAIL pfhit counters: got h=%0d p=%0d expected h=%0d p=%0d",
        hit_cnt_o, pf_cnt_o, sat(exp_hit), sat(exp_pf));
    end
    tick();
  endtask

  // Demand miss during a prefetch burst waits, then fills; chain dropped.
  task automatic test_pf_fill_miss();
    pf_enable_i = 1; mem_read = 1; hit_i = 4'b0010; valid_i = 4'hF;
    #1; tick(); exp_hit++;
    mem_read = 0; hit_i = 0; pf_enable_i = 0;
    nhit_i = 0; nvalid_i = 4'hF; nlru_i = 3'b011;
    #1;
    checks++;
    if ({load_pf_line_o, pf_offset_o} !== {1'b1, 3'd1}) begin
      failures++; $display("FAIL pfmiss probe: got ld=%b off=%0d expected 1/1", load_pf_line_o, pf_offset_o);
    end
    tick(); exp_pf++;
    mem_read = 1; hit_i = 0; valid_i = 4'hF; lru_i = 3'b000;
    for (int c = 1; c <= 4; c++) begin
      pmem_resp = (c == 4);
      #1;
      checks++;
      if ({mem_resp, pmem_read, paddr_sel_o, pf_way_o, pf_load_o} !== {1'b0, 1'b1, 1'b1, 2'd0, (c == 4)}) begin
        failures++; $display("FAIL pfmiss wait c=%0d: got %b expected %b", c,
          {mem_resp, pmem_read, paddr_sel_o, pf_way_o, pf_load_o}, {1'b0, 1'b1, 1'b1, 2'd0, (c == 4)});
      end
      if (c == 2) begin
        checks++;
        if (miss_cnt_o !== sat(exp_miss)) begin
          failures++; $display("FAIL pfmiss stall_count: got %0d expected %0d", miss_cnt_o, sat(exp_miss));
        end
      end
      tick();
    end
    pmem_resp = 0;
    #1;
    checks++;
    if ({mem_resp, pmem_read, pf_offset_o, load_pf_line_o} !== 6'd0) begin
      failures++; $display("FAIL pfmiss recheck: got %b expected 0",
        {mem_resp, pmem_read, pf_offset_o, load_pf_line_o});
    end
    tick(); exp_miss++;
    for (int c = 1; c <= 2; c++) begin
      pmem_resp = (c == 2);
      #1;
      checks++;
      if ({pmem_read, paddr_sel_o, fill_way_o, fill_load_o} !== {1'b1, 1'b0, 2'd3, (c == 2)}) begin
        failures++; $display("FAIL pfmiss fill c=%0d: got %b expected %b", c,
          {pmem_read, paddr_sel_o, fill_way_o, fill_load_o}, {1'b1, 1'b0, 2'd3, (c == 2)});
      end
      tick();
    end
    pmem_resp = 0; hit_i = 4'b1000;
    #1;
    checks++;
    if ({mem_resp, dout_way_o} !== {1'b1, 2'd3}) begin
      failures++; $display("FAIL pfmiss served: got resp=%b way=%0d expected 1/3", mem_resp, dout_way_o);
    end
    tick(); exp_hit++;
    mem_read = 0; hit_i = 0;
    #1;
    checks++;
    if ({hit_cnt_o, miss_cnt_o, pf_cnt_o} !== {sat(exp_hit), sat(exp_miss), sat(exp_pf)}) begin
      failures++; $display("FAIL pfmiss counters: got h=%0d m=%0d p=%0d expected h=%0d m=%0d p=%0d",
        hit_cnt_o, miss_cnt_o, pf_cnt_o, sat(exp_hit), sat(exp_miss), sat(exp_pf));
    end
    tick();
  endtask

  // Random hit/miss traffic with prefetch off; drives hit counter into saturation.
  task automatic test_random_demand(input int n);
    logic [3:0] vld;
    logic [2:0] lru;
    int         way, lat;
    for (int i = 0; i < n; i++) begin
      vld = 4'($urandom);
      lru = 3'($urandom);
      lat = $urandom_range(1, 6);
      way = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, 3);
      if (way >= 0) vld[way] = 1'b1;
      demand($sformatf("rand%0d", i), vld, lru, way, lat);
    end
  endtask

  task automatic test_reset_mid_fill();
    pf_enable_i = 0; mem_read = 1; hit_i = 0; valid_i = 0;
    #1; tick();
    #1;
    checks++;
    if (pmem_read !== 1'b1) begin
      failures++; $display("FAIL rstfill in_fill: got pmem_read=%b expected 1", pmem_read);
    end
    #1 rst_n = 0; pmem_resp = 1;
    #1;
    checks++;
    if ({pmem_read, fill_load_o, pf_load_o} !== 3'd0) begin
      failures++; $display("FAIL rstfill async_drop: got %b expected 0", {pmem_read, fill_load_o, pf_load_o});
    end
    checks++;
    if ({hit_cnt_o, miss_cnt_o, pf_cnt_o} !== '0) begin
      failures++; $display("FAIL rstfill counters: got %h expected 0", {hit_cnt_o, miss_cnt_o, pf_cnt_o});
    end
    exp_hit = 0; exp_miss = 0; exp_pf = 0;
    #2 rst_n = 1;
    mem_read = 0;
    #1;
    checks++;
    if ({pmem_read, fill_load_o, pf_load_o, mem_resp} !== 4'd0) begin
      failures++; $display("FAIL rstfill after_release: got %b expected 0",
        {pmem_read, fill_load_o, pf_load_o, mem_resp});
    end
    tick();
    pmem_resp = 0;
    demand("post_reset_hit", 4'b0001, 3'b000, 0, 1);
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_victim_select();
    test_prefetch_chain(5);
    test_pf_fill_hits();
    test_pf_fill_miss();
    test_random_demand(24);
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
